// File: rtl/ps2_kbd_manager.sv
// ps2_kbd_manager: PS/2 keyboard command sequencer (reset, LED programming with retries)
// plus a set-2 scan-code decoder that tracks E0/F0 prefixes.
module ps2_kbd_manager #(
    parameter int ACK_TIMEOUT = 2500000,
    parameter int MAX_TRIES   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       led_req,
    input  logic [2:0] led_state,
    output logic       busy,
    output logic       init_done,
    output logic       cmd_error,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {INIT, SEND, WAIT_SENT, WAIT_ACK, WAIT_BAT, IDLE, LED_ARG} state_t;

    state_t state, state_n;
    logic [7:0] cmd_n;
    logic send_n, init_n, err_n, retry;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tries, tries_n;
    logic [2:0] leds, leds_n;
    logic ext_f, brk_f;

    wire rx_fa   = received_data_en && received_data == 8'hFA;
    wire rx_fe   = received_data_en && received_data == 8'hFE;
    wire rx_aa   = received_data_en && received_data == 8'hAA;
    wire rx_fc   = received_data_en && received_data == 8'hFC;
    wire timeout = cnt == CW'(ACK_TIMEOUT);

    assign busy = state != IDLE;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= INIT;
            the_command  <= 8'h00;
            send_command <= 1'b0;
            cnt          <= '0;
            tries        <= '0;
            leds         <= '0;
            init_done    <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            state        <= state_n;
            the_command  <= cmd_n;
            send_command <= send_n;
            cnt          <= cnt_n;
            tries        <= tries_n;
            leds         <= leds_n;
            init_done    <= init_n;
            cmd_error    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cmd_n   = the_command;
        send_n  = send_command;
        cnt_n   = cnt;
        tries_n = tries;
        leds_n  = leds;
        init_n  = init_done;
        err_n   = cmd_error;
        retry   = 1'b0;
        case (state)
            INIT: begin
                cmd_n   = 8'hFF;
                tries_n = '0;
                state_n = SEND;
            end
            SEND: begin
                send_n  = 1'b1;
                state_n = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (command_was_sent) begin
                    send_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = WAIT_ACK;
                end else if (error_communication_timed_out) begin
                    send_n = 1'b0;
                    retry  = 1'b1;
                end
            end
            WAIT_ACK: begin
                cnt_n = cnt + CW'(1);
                if (rx_fa) begin
                    cnt_n   = '0;
                    state_n = the_command == 8'hFF ? WAIT_BAT :
                              the_command == 8'hED ? LED_ARG : IDLE;
                end else if (rx_fe || timeout) begin
                    retry = 1'b1;
                end
            end
            WAIT_BAT: begin
                cnt_n = cnt + CW'(1);
                if (rx_aa) begin
                    init_n  = 1'b1;
                    state_n = IDLE;
                end else if (rx_fc || timeout) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (led_req) begin
                    cmd_n   = 8'hED;
                    leds_n  = led_state;
                    tries_n = '0;
                    state_n = SEND;
                end
            end
            LED_ARG: begin
                cmd_n   = {5'b0, leds};
                tries_n = '0;
                state_n = SEND;
            end
            default: state_n = INIT;
        endcase
        // A failed attempt resends the same byte until the attempt budget is spent
        if (retry) begin
            tries_n = tries + TW'(1);
            if (tries_n < TW'(MAX_TRIES)) begin
                state_n = SEND;
            end else begin
                err_n   = 1'b1;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_valid <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            // Protocol replies and error codes are not key events
            if (received_data_en &&
                !(received_data inside {8'hFA, 8'hFE, 8'hAA, 8'hFC, 8'hEE, 8'h00, 8'hFF})) begin
                if (received_data == 8'hE0) begin
                    ext_f <= 1'b1;
                end else if (received_data == 8'hF0) begin
                    brk_f <= 1'b1;
                end else if (received_data == 8'hE1) begin
                    ext_f <= 1'b0;
                    brk_f <= 1'b0;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= received_data;
                    key_ext   <= ext_f;
                    key_break <= brk_f;
                    ext_f     <= 1'b0;
                    brk_f     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbd_manager.sv
// tb_ps2_kbd_manager: scoreboard bench; expected command bytes and key events are queued
// by the stimulus and checked by a monitor whenever the DUT presents them.
module tb_ps2_kbd_manager;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] the_command;
    logic       send_command;
    logic       led_req = 1'b0;
    logic [2:0] led_state = 3'b000;
    logic       busy, init_done, cmd_error, key_valid, key_code_unused;
    logic [7:0] key_code;
    logic       key_ext, key_break;

    int assertions = 0;
    int failures = 0;

    logic [7:0] exp_cmd[$];
    logic [9:0] exp_key[$];
    logic       prev_send = 1'b0;

    localparam logic [8:0] NONE = 9'h100;

    ps2_kbd_manager #(.ACK_TIMEOUT(100), .MAX_TRIES(3)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .received_data(received_data), .received_data_en(received_data_en),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .the_command(the_command), .send_command(send_command),
        .led_req(led_req), .led_state(led_state),
        .busy(busy), .init_done(init_done), .cmd_error(cmd_error),
        .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising send_command and every key_valid strobe is scored
    always @(negedge CLOCK_50) begin
        if (send_command && !prev_send) begin
            if (exp_cmd.size() == 0) chk("unexpected_send", {24'h0, the_command}, 32'hDEAD);
            else chk("the_command", {24'h0, the_command}, {24'h0, exp_cmd.pop_front()});
        end
        prev_send <= send_command;
        if (key_valid) begin
            if (exp_key.size() == 0) chk("unexpected_key", {22'h0, key_code, key_ext, key_break}, 32'hDEAD);
            else chk("key_event", {22'h0, key_code, key_ext, key_break}, {22'h0, exp_key.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(1);
        received_data = b;
        received_data_en = 1'b1;
        tick(1);
        received_data_en = 1'b0;
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b1;
        tick(3);
        exp_cmd.push_back(8'hFF);
        reset = 1'b0;
        tick(1);
        chk("send_cycle1", {31'h0, send_command}, 32'h0);
        tick(1);
        chk("send_cycle2", {31'h0, send_command}, 32'h1);
    endtask

    // Keyboard side of one transmit attempt: accept the byte, then optionally reply
    task automatic xfer(input logic [8:0] resp);
        int n = 0;
        while (!send_command && n < 300) begin
            tick(1);
            n++;
        end
        if (!send_command) chk("send_wait_timeout", 32'h0, 32'h1);
        tick(2);
        command_was_sent = 1'b1;
        tick(1);
        command_was_sent = 1'b0;
        chk("send_drop", {31'h0, send_command}, 32'h0);
        if (!resp[8]) begin
            tick(3);
            send_byte(resp[7:0]);
        end
    endtask

    task automatic init_ok();
        do_reset();
        xfer(9'h0FA);
        tick(3);
        send_byte(8'hAA);
        tick(2);
        chk("init_done", {31'h0, init_done}, 32'h1);
    endtask

    initial begin
        tick(2);
        chk("rst_send", {31'h0, send_command}, 32'h0);
        chk("rst_cmd", {24'h0, the_command}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_init", {31'h0, init_done}, 32'h0);
        chk("rst_err", {31'h0, cmd_error}, 32'h0);
        chk("rst_key", {22'h0, key_valid, key_code, key_ext}, 32'h0);

        // Clean init: FF acked then BAT passes
        init_ok();
        chk("init1_busy", {31'h0, busy}, 32'h0);
        chk("init1_err", {31'h0, cmd_error}, 32'h0);

        // Init with two resend requests
        do_reset();
        exp_cmd.push_back(8'hFF);
        exp_cmd.push_back(8'hFF);
        xfer(9'h0FE);
        xfer(9'h0FE);
        xfer(9'h0FA);
        tick(3);
        send_byte(8'hAA);
        tick(2);
        chk("init2_done", {31'h0, init_done}, 32'h1);
        chk("init2_queue", exp_cmd.size(), 32'h0);

        // Silent keyboard: three attempts time out
        do_reset();
        exp_cmd.push_back(8'hFF);
        exp_cmd.push_back(8'hFF);
        xfer(NONE);
        xfer(NONE);
        xfer(NONE);
        tick(150);
        chk("to_err", {31'h0, cmd_error}, 32'h1);
        chk("to_init", {31'h0, init_done}, 32'h0);
        chk("to_busy", {31'h0, busy}, 32'h0);
        chk("to_queue", exp_cmd.size(), 32'h0);

        // LED programming, with a request during the sequence that must be dropped
        init_ok();
        led_state = 3'b101;
        exp_cmd.push_back(8'hED);
        exp_cmd.push_back(8'h05);
        led_req = 1'b1;
        tick(1);
        led_req = 1'b0;
        led_state = 3'b010;
        chk("led_busy", {31'h0, busy}, 32'h1);
        xfer(9'h0FA);
        led_req = 1'b1;
        tick(1);
        led_req = 1'b0;
        xfer(9'h0FA);
        tick(3);
        chk("led_idle", {31'h0, busy}, 32'h0);
        tick(10);
        chk("led_queue", exp_cmd.size(), 32'h0);

        // Scan decoding, with protocol bytes interleaved
        exp_key.push_back({8'h75, 1'b1, 1'b1});
        send_byte(8'hE0);
        send_byte(8'hFA);
        send_byte(8'hF0);
        send_byte(8'h75);
        exp_key.push_back({8'h1C, 1'b0, 1'b0});
        send_byte(8'hAA);
        send_byte(8'h1C);
        tick(3);
        chk("key_hold", {22'h0, key_code, key_ext, key_break}, {22'h0, 8'h1C, 2'b00});
        exp_key.push_back({8'h6B, 1'b0, 1'b0});
        send_byte(8'hE0);
        send_byte(8'hE1);
        send_byte(8'h6B);
        tick(3);
        chk("key_queue", exp_key.size(), 32'h0);

        // Reset while waiting for the ED acknowledge restarts with FF
        exp_cmd.push_back(8'hED);
        led_req = 1'b1;
        tick(1);
        led_req = 1'b0;
        xfer(NONE);
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("rst_mid_send", {31'h0, send_command}, 32'h0);
        chk("rst_mid_init", {31'h0, init_done}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h1);
        init_ok();
        tick(5);
        chk("final_queue", exp_cmd.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_manager.md
PS2_KBD_MANAGER -- requirements
Module: ps2_kbd_manager

Interface
REQ-001 Parameter ACK_TIMEOUT, default 2500000, meaning CLOCK_50 cycles (50 ms) allowed between command_was_sent and a keyboard response byte.
REQ-002 Parameter MAX_TRIES, default 3, meaning total transmit attempts per command byte before giving up.
REQ-003 CLOCK_50  input  1  system clock, all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 received_data  input  8  byte from PS2 controller.
REQ-006 received_data_en  input  1  one-cycle strobe, received_data valid.
REQ-007 command_was_sent  input  1  controller finished transmitting the_command.
REQ-008 error_communication_timed_out  input  1  controller transmit failure.
REQ-009 the_command  output  8  byte to transmit.
REQ-010 send_command  output  1  transmit request to controller (level).
REQ-011 led_req  input  1  one-cycle request to program keyboard LEDs.
REQ-012 led_state  input  3  {caps, num, scroll}, sampled when led_req accepted.
REQ-013 busy  output  1  high while any command sequence is in progress.
REQ-014 init_done  output  1  high once keyboard reset (FF/FA/AA) completed.
REQ-015 cmd_error  output  1  sticky; set when a command exhausts MAX_TRIES or BAT fails; cleared only by reset.
REQ-016 key_valid  output  1  one-cycle strobe, key event valid.
REQ-017 key_code  output  8  set-2 scan code of event.
REQ-018 key_ext  output  1  event was E0-prefixed.
REQ-019 key_break  output  1  event was a release (F0-prefixed).

Function
REQ-020 Command FSM states: INIT, SEND, WAIT_SENT, WAIT_ACK, WAIT_BAT, IDLE, LED_ARG.
REQ-021 INIT: load the_command=FF, go SEND; after reset exit, first send_command rises on cycle 2.
REQ-022 SEND: drive send_command=1, go WAIT_SENT; send_command held high until command_was_sent or error_communication_timed_out sampled high, deasserted the following cycle, the_command stable throughout.
REQ-023 WAIT_SENT: command_was_sent -> WAIT_ACK, clear timeout counter; error_communication_timed_out -> retry path.
REQ-024 WAIT_ACK: received FA -> next step; FE -> retry path; counter reaching ACK_TIMEOUT -> retry path; other bytes ignored by FSM.
REQ-025 Retry path: increment try count; if count < MAX_TRIES re-enter SEND with same byte, else set cmd_error and go IDLE (init_done stays 0 if during init).
REQ-026 Next step after FA: FF -> WAIT_BAT; ED -> LED_ARG; LED argument byte -> IDLE.
REQ-027 WAIT_BAT: AA -> init_done=1, IDLE; FC or timeout -> cmd_error=1, IDLE.
REQ-028 IDLE: led_req accepted only here; loads ED, latches led_state, go SEND; led_req outside IDLE is dropped.
REQ-029 LED_ARG: load {5'b0, caps, num, scroll} order {scroll=bit0, num=bit1, caps=bit2}, try count reset, go SEND.
REQ-030 busy = 1 in every state except IDLE.
REQ-031 Bytes FA, FE, AA, FC, EE, 00, FF never reach scan decoder.
REQ-032 Decoder: E0 sets ext flag, F0 sets break flag, E1 clears both flags and is dropped; any other byte emits key_valid with key_code, key_ext, key_break on the cycle after received_data_en, then clears flags.
REQ-033 Decoder operates in all command states; E0 F0 sequences retain both flags.
REQ-034 Key outputs hold last event between strobes.

Reset
REQ-035 On reset: FSM=INIT, send_command=0, the_command=00, busy=1, init_done=0, cmd_error=0, key_valid=0, key_code=00, key_ext=0, key_break=0, flags, counters, try count cleared.
REQ-036 Reset mid-transfer abandons sequence; init restarts with FF.

Verification
REQ-037 Reset, model sends FA then AA after command_was_sent -> the_command=FF seen once, init_done=1, busy=0, cmd_error=0.
REQ-038 Init, model answers FE twice then FA, AA -> exactly 3 FF transmissions, init_done=1.
REQ-039 Init, model never answers (ACK_TIMEOUT=100) -> 3 FF transmissions, cmd_error=1, init_done=0, busy=0.
REQ-040 After init, led_req with led_state=3'b101, FA to each byte -> ED then 05 sent, busy returns 0.
REQ-041 Bytes E0 F0 75 -> single key_valid, key_code=75, key_ext=1, key_break=1; then 1C -> key_code=1C, ext=0, break=0.
REQ-042 Reset asserted during WAIT_ACK of ED -> send_command=0 next cycle, sequence restarts with FF.
